// File: rtl/click_event_encoder.sv
// -----------------------------------------------------------------------------
// click_event_encoder
//
// Producer side of the mouse-click interface used by the picture toggle logic.
// The raw left button is synchronised into clk, debounced, and the press and
// release positions are hit-tested against a 2x2 grid of screen tiles. A press
// followed by a release inside the same tile is a qualified click: it flips
// that tile's toggle bit and is offered downstream through a one-entry
// valid/ready output register.
//
// Ports
//   clk           in   1   pixel clock
//   rst           in   1   synchronous reset, active-high
//   mouse_left    in   1   raw left button, asynchronous to clk
//   xpos          in   12  mouse x, clk domain
//   ypos          in   12  mouse y, clk domain
//   evt_ready     in   1   consumer accepts event
//   evt_valid     out  1   click event pending
//   evt_region    out  2   tile index of pending event, row*2+col
//   evt_overflow  out  1   sticky: qualified click dropped, output was occupied
//   toggle        out  4   per-tile toggle bit, flips on every qualified click
//   left_db       out  1   debounced button level
// -----------------------------------------------------------------------------
module click_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int X_ORIGIN        = 100,
    parameter int Y_ORIGIN        = 100,
    parameter int CELL_W          = 200,
    parameter int CELL_H          = 150
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        evt_ready,
    output logic        evt_valid,
    output logic [1:0]  evt_region,
    output logic        evt_overflow,
    output logic [3:0]  toggle,
    output logic        left_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Grid edges in 13 bits so origin + 2*cell never wraps.
    localparam logic [12:0] X_LO  = 13'(X_ORIGIN);
    localparam logic [12:0] X_MID = 13'(X_ORIGIN + CELL_W);
    localparam logic [12:0] X_HI  = 13'(X_ORIGIN + 2 * CELL_W);
    localparam logic [12:0] Y_LO  = 13'(Y_ORIGIN);
    localparam logic [12:0] Y_MID = 13'(Y_ORIGIN + CELL_H);
    localparam logic [12:0] Y_HI  = 13'(Y_ORIGIN + 2 * CELL_H);

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. sync_fill marks when left_s reflects a real
    // post-reset sample of the button rather than the reset value.
    // -------------------------------------------------------------------------
    logic       sync_1;
    logic       left_s;
    logic [1:0] sync_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= 1'b0;
            left_s    <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            sync_1    <= mouse_left;
            left_s    <= sync_1;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: left_db follows left_s only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt  <= '0;
            left_db <= 1'b0;
        end else if (left_s == left_db) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            left_db <= ~left_db;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // Previous debounced level, for rise detection.
    logic left_db_q;
    // Armed once the button has been seen released after reset, so a button
    // held through reset cannot masquerade as a fresh press.
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            left_db_q <= 1'b0;
            armed     <= 1'b0;
        end else begin
            left_db_q <= left_db;
            if (sync_fill[1] && !left_s && !left_db)
                armed <= 1'b1;
        end
    end

    logic db_rise;
    assign db_rise = left_db & ~left_db_q;

    // -------------------------------------------------------------------------
    // Hit test on the current cursor position (half-open tile ranges).
    // -------------------------------------------------------------------------
    logic [12:0] x13;
    logic [12:0] y13;
    logic        col_in;
    logic        row_in;
    logic        cur_hit;
    logic [1:0]  cur_region;

    assign x13        = {1'b0, xpos};
    assign y13        = {1'b0, ypos};
    assign col_in     = (x13 >= X_LO) && (x13 < X_HI);
    assign row_in     = (y13 >= Y_LO) && (y13 < Y_HI);
    assign cur_hit    = col_in && row_in;
    assign cur_region = {(y13 >= Y_MID), (x13 >= X_MID)};

    // -------------------------------------------------------------------------
    // Click FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    logic       press_hit;
    logic [1:0] press_region;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (armed && db_rise)
                    state_nxt = PRESSED;
            end
            PRESSED: begin
                // Only the release endpoint matters; cursor travel while held
                // is ignored.
                if (!left_db) begin
                    if (press_hit && cur_hit && (cur_region == press_region))
                        state_nxt = EMIT;
                    else
                        state_nxt = IDLE;
                end
            end
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic latch_press;
    logic emit;

    always_comb begin
        latch_press = 1'b0;
        emit        = 1'b0;
        case (state)
            IDLE:    latch_press = armed && db_rise;
            EMIT:    emit        = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_hit    <= 1'b0;
            press_region <= 2'd0;
        end else if (latch_press) begin
            press_hit    <= cur_hit;
            press_region <= cur_region;
        end
    end

    // -------------------------------------------------------------------------
    // Output register and per-tile toggles. A pending event accepted on the
    // EMIT cycle frees the slot for the new one in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid    <= 1'b0;
            evt_region   <= 2'd0;
            evt_overflow <= 1'b0;
            toggle       <= 4'd0;
        end else if (emit) begin
            toggle[press_region] <= ~toggle[press_region];
            if (!evt_valid || evt_ready) begin
                evt_valid  <= 1'b1;
                evt_region <= press_region;
            end else begin
                evt_overflow <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule
